// File: rtl/instr_mem_pkg.sv
// Shared constants for the instruction memory fetch pipeline.
//   FAULT_MISALIGN / FAULT_RANGE : bit positions inside the 2-bit fault word
//   NOP_DEFAULT                  : instruction returned after reset and on faults
package instr_mem_pkg;

    localparam int FAULT_W        = 2;
    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    localparam logic [15:0] NOP_DEFAULT = 16'h0000;

    // Bytes per instruction word for a given instruction width.
    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: DEPTH x DATA_W words, one synchronous write port and
// one synchronous (registered) read port. Contents are never reset.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data written on the rising edge
//   rd_en   : read strobe; rd_data updates only when set, otherwise holds
//   rd_data : registered read data, valid the cycle after rd_en
module instr_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The output register holds while rd_en is low, so a stalled response
    // stays stable even if the addressed word is rewritten meanwhile.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/instr_mem_pipe.sv
// Single-cycle-latency instruction fetch unit with program load port.
//   clk, reset            : clock, synchronous active-high reset
//   ld_en/ld_addr/ld_data : program load (aligned, in-range words only)
//   req_valid/req_seq/addr_in, req_ready : fetch request handshake;
//                           req_seq fetches from the internal sequential pointer
//   rsp_valid/rsp_ready   : response handshake
//   addr_out, instruc_out : returned byte address and instruction
//   fault                 : bit0 misaligned, bit1 out-of-range (with rsp_valid)
module instr_mem_pipe
    import instr_mem_pkg::*;
#(
    parameter int                 ADDR_W    = 8,
    parameter int                 DATA_W    = 16,
    parameter int                 DEPTH     = 128,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NOP_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    input  logic               req_valid,
    input  logic               req_seq,
    input  logic [ADDR_W-1:0]  addr_in,
    output logic               req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ADDR_W-1:0]  addr_out,
    output logic [DATA_W-1:0]  instruc_out,
    output logic [1:0]         fault
);

    localparam int WB     = word_bytes(DATA_W);
    localparam int AL     = $clog2(WB);
    localparam int IDX_W  = ADDR_W - AL;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Address checker lanes: lane 0 = fetch address, lane 1 = load address.
    localparam int LANE_FETCH = 0;
    localparam int LANE_LOAD  = 1;

    logic [ADDR_W-1:0] chk_addr [2];
    logic [IDX_W-1:0]  chk_idx  [2];
    logic              chk_mis  [2];
    logic              chk_rng  [2];

    logic               rsp_valid_reg;
    logic [ADDR_W-1:0]  addr_out_reg;
    logic [1:0]         fault_reg;
    logic [DATA_W-1:0]  hold_data_reg;
    logic               sel_ram_reg;
    logic [ADDR_W-1:0]  next_seq_reg;

    logic [ADDR_W-1:0]  fetch_addr;
    logic [1:0]         fetch_fault;
    logic               accept;
    logic               load_ok;
    logic               bypass;
    logic [DATA_W-1:0]  ram_rd_data;

    assign fetch_addr           = req_seq ? next_seq_reg : addr_in;
    assign chk_addr[LANE_FETCH] = fetch_addr;
    assign chk_addr[LANE_LOAD]  = ld_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chk
            assign chk_idx[gi] = chk_addr[gi][ADDR_W-1:AL];
            if (AL == 0) begin : g_byte
                assign chk_mis[gi] = 1'b0;
            end else begin : g_word
                assign chk_mis[gi] = |chk_addr[gi][AL-1:0];
            end
            assign chk_rng[gi] = 32'(chk_idx[gi]) >= 32'(DEPTH);
        end
    endgenerate

    assign req_ready = !rsp_valid_reg || rsp_ready;
    assign accept    = req_valid && req_ready && !reset;
    assign load_ok   = ld_en && !reset && !chk_mis[LANE_LOAD] && !chk_rng[LANE_LOAD];

    always_comb begin
        fetch_fault                 = '0;
        fetch_fault[FAULT_MISALIGN] = chk_mis[LANE_FETCH];
        fetch_fault[FAULT_RANGE]    = chk_rng[LANE_FETCH];
    end

    // The array's read-during-write result is not relied on: a same-word
    // load and fetch take the load data straight into the response.
    assign bypass = load_ok && (fetch_fault == '0) &&
                    (chk_idx[LANE_LOAD] == chk_idx[LANE_FETCH]);

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (load_ok),
        .wr_addr (chk_idx[LANE_LOAD][MEM_AW-1:0]),
        .wr_data (ld_data),
        .rd_en   (accept && (fetch_fault == '0) && !bypass),
        .rd_addr (chk_idx[LANE_FETCH][MEM_AW-1:0]),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            addr_out_reg  <= '0;
            fault_reg     <= '0;
            hold_data_reg <= NOP_INSTR;
            sel_ram_reg   <= 1'b0;
            next_seq_reg  <= '0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            addr_out_reg  <= fetch_addr;
            fault_reg     <= fetch_fault;
            next_seq_reg  <= fetch_addr + ADDR_W'(WB);
            if (fetch_fault != '0) begin
                hold_data_reg <= NOP_INSTR;
                sel_ram_reg   <= 1'b0;
            end else if (bypass) begin
                hold_data_reg <= ld_data;
                sel_ram_reg   <= 1'b0;
            end else begin
                sel_ram_reg   <= 1'b1;
            end
        end else if (rsp_ready) begin
            // Response consumed with nothing behind it; data outputs hold.
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign addr_out    = addr_out_reg;
    assign fault       = fault_reg;
    assign instruc_out = sel_ram_reg ? ram_rd_data : hold_data_reg;

endmodule

// File: tb/tb_instr_mem_pipe.sv
module tb_instr_mem_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        req_valid;
    logic        req_seq;
    logic [7:0]  addr_in;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  addr_out;
    logic [15:0] instruc_out;
    logic [1:0]  fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_mem_pipe #(
        .ADDR_W    (8),
        .DATA_W    (16),
        .DEPTH     (16),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .req_valid   (req_valid),
        .req_seq     (req_seq),
        .addr_in     (addr_in),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .addr_out    (addr_out),
        .instruc_out (instruc_out),
        .fault       (fault)
    );

    typedef struct {
        string       name;
        logic        ld_en;
        logic [7:0]  ld_addr;
        logic [15:0] ld_data;
        logic        req_valid;
        logic        req_seq;
        logic [7:0]  addr_in;
        logic        rsp_ready;
        logic        exp_valid;
        logic [7:0]  exp_addr;
        logic [15:0] exp_instr;
        logic [1:0]  exp_fault;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic le, input logic [7:0] la, input logic [15:0] ld,
                         input logic rv, input logic rs, input logic [7:0] ai, input logic rr);
        ld_en = le; ld_addr = la; ld_data = ld;
        req_valid = rv; req_seq = rs; addr_in = ai; rsp_ready = rr;
    endtask

    task automatic check_rsp(input string name, input logic v, input logic [7:0] a,
                             input logic [15:0] d, input logic [1:0] f);
        check({name, ".rsp_valid"}, 32'(rsp_valid), 32'(v));
        check({name, ".addr_out"}, 32'(addr_out), 32'(a));
        check({name, ".instruc_out"}, 32'(instruc_out), 32'(d));
        check({name, ".fault"}, 32'(fault), 32'(f));
        $display("%s: valid=%0b addr=%02h instr=%04h fault=%02b", name, rsp_valid, addr_out, instruc_out, fault);
    endtask

    function automatic vec_t mk(input string n, input logic le, input logic [7:0] la,
                                input logic [15:0] ld, input logic rv, input logic rs,
                                input logic [7:0] ai, input logic rr, input logic ev,
                                input logic [7:0] ea, input logic [15:0] ei, input logic [1:0] ef);
        vec_t v;
        v.name = n; v.ld_en = le; v.ld_addr = la; v.ld_data = ld;
        v.req_valid = rv; v.req_seq = rs; v.addr_in = ai; v.rsp_ready = rr;
        v.exp_valid = ev; v.exp_addr = ea; v.exp_instr = ei; v.exp_fault = ef;
        return v;
    endfunction

    initial begin
        //              name           ld ldaddr ldata    rv sq addr  rr  ev eaddr einstr   efault
        vecs[0]  = mk("load00",        1, 8'h00, 16'hF120, 0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 2'b00);
        vecs[1]  = mk("load04",        1, 8'h04, 16'h93FF, 0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 2'b00);
        vecs[2]  = mk("load02",        1, 8'h02, 16'h1111, 0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 2'b00);
        vecs[3]  = mk("load06",        1, 8'h06, 16'h2222, 0, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 2'b00);
        vecs[4]  = mk("fetch04",       0, 8'h00, 16'h0000, 1, 0, 8'h04, 1, 1, 8'h04, 16'h93FF, 2'b00);
        vecs[5]  = mk("fetch00",       0, 8'h00, 16'h0000, 1, 0, 8'h00, 1, 1, 8'h00, 16'hF120, 2'b00);
        vecs[6]  = mk("seq02",         0, 8'h00, 16'h0000, 1, 1, 8'hAA, 1, 1, 8'h02, 16'h1111, 2'b00);
        vecs[7]  = mk("seq04",         0, 8'h00, 16'h0000, 1, 1, 8'hAA, 1, 1, 8'h04, 16'h93FF, 2'b00);
        vecs[8]  = mk("seq06",         0, 8'h00, 16'h0000, 1, 1, 8'hAA, 1, 1, 8'h06, 16'h2222, 2'b00);
        vecs[9]  = mk("misalign03",    0, 8'h00, 16'h0000, 1, 0, 8'h03, 1, 1, 8'h03, 16'h0000, 2'b01);
        vecs[10] = mk("range40",       0, 8'h00, 16'h0000, 1, 0, 8'h40, 1, 1, 8'h40, 16'h0000, 2'b10);
        vecs[11] = mk("both41",        0, 8'h00, 16'h0000, 1, 0, 8'h41, 1, 1, 8'h41, 16'h0000, 2'b11);
        vecs[12] = mk("drain",         0, 8'h00, 16'h0000, 0, 0, 8'h00, 1, 0, 8'h41, 16'h0000, 2'b11);
        vecs[13] = mk("bypass08",      1, 8'h08, 16'hABCD, 1, 0, 8'h08, 1, 1, 8'h08, 16'hABCD, 2'b00);
        vecs[14] = mk("reread08",      0, 8'h00, 16'h0000, 1, 0, 8'h08, 1, 1, 8'h08, 16'hABCD, 2'b00);
        vecs[15] = mk("badload03",     1, 8'h03, 16'h5555, 0, 0, 8'h00, 1, 0, 8'h08, 16'hABCD, 2'b00);
        vecs[16] = mk("fetch02",       0, 8'h00, 16'h0000, 1, 0, 8'h02, 1, 1, 8'h02, 16'h1111, 2'b00);
        vecs[17] = mk("rangeFE",       0, 8'h00, 16'h0000, 1, 0, 8'hFE, 1, 1, 8'hFE, 16'h0000, 2'b10);
        vecs[18] = mk("seqwrap00",     0, 8'h00, 16'h0000, 1, 1, 8'hAA, 1, 1, 8'h00, 16'hF120, 2'b00);
        vecs[19] = mk("idle",          0, 8'h00, 16'h0000, 0, 0, 8'h00, 1, 0, 8'h00, 16'hF120, 2'b00);

        // Reset state
        reset = 1'b1;
        drive(0, 8'h00, 16'h0000, 0, 0, 8'h00, 1);
        repeat (2) @(posedge clk);
        #1;
        check_rsp("reset", 0, 8'h00, 16'h0000, 2'b00);
        reset = 1'b0;
        #1;
        check("reset.req_ready", 32'(req_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ld_en, vecs[i].ld_addr, vecs[i].ld_data, vecs[i].req_valid,
                  vecs[i].req_seq, vecs[i].addr_in, vecs[i].rsp_ready);
            @(posedge clk);
            #1;
            check_rsp(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_addr,
                      vecs[i].exp_instr, vecs[i].exp_fault);
        end

        // Back-pressure: response must hold and the queued fetch waits.
        drive(0, 8'h00, 16'h0000, 1, 0, 8'h04, 1);
        @(posedge clk); #1;
        check_rsp("stall.first", 1, 8'h04, 16'h93FF, 2'b00);
        drive(0, 8'h00, 16'h0000, 1, 0, 8'h00, 0);
        #1;
        check("stall.req_ready0", 32'(req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_rsp($sformatf("stall.hold%0d", c), 1, 8'h04, 16'h93FF, 2'b00);
            check($sformatf("stall.req_ready%0d", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("stall.release_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check_rsp("stall.accepted", 1, 8'h00, 16'hF120, 2'b00);

        // Reset mid-operation with a pending, unconsumed response.
        drive(0, 8'h00, 16'h0000, 1, 0, 8'h06, 1);
        @(posedge clk); #1;
        check_rsp("prereset", 1, 8'h06, 16'h2222, 2'b00);
        reset = 1'b1;
        drive(1, 8'h00, 16'hDEAD, 1, 0, 8'h04, 0);
        @(posedge clk); #1;
        check_rsp("midreset", 0, 8'h00, 16'h0000, 2'b00);
        reset = 1'b0;
        drive(0, 8'h00, 16'h0000, 0, 0, 8'h00, 0);
        #1;
        check("postreset.req_ready", 32'(req_ready), 32'd1);
        drive(0, 8'h00, 16'h0000, 1, 1, 8'h44, 1);
        @(posedge clk); #1;
        check_rsp("postreset.seq00", 1, 8'h00, 16'hF120, 2'b00);
        drive(0, 8'h00, 16'h0000, 1, 0, 8'h04, 1);
        @(posedge clk); #1;
        check_rsp("postreset.fetch04", 1, 8'h04, 16'h93FF, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
